// File: rtl/barrel_pkg.sv
// Shared types and the single-stage shift helper for the pipelined barrel shifter.
package barrel_pkg;

   typedef enum logic [1:0] {
      OP_ROR = 2'b00,
      OP_ROL = 2'b01,
      OP_SRL = 2'b10,
      OP_SRA = 2'b11
   } op_e;

   // Widest word any instance may carry (N up to 6).
   localparam int MaxWidth = 64;

   // One stage's shift of a w-bit word held in the low bits of data.
   // k is always a power of two no larger than w/2, so w-k never reaches zero.
   function automatic logic [MaxWidth-1:0] shift_step(input logic [MaxWidth-1:0] data,
                                                      input int unsigned       w,
                                                      input int unsigned       k,
                                                      input op_e               op);
      logic [MaxWidth-1:0] mask;
      logic [MaxWidth-1:0] d;
      logic [MaxWidth-1:0] msb_vec;
      logic [MaxWidth-1:0] fill;
      // (1 << 64) wraps to zero, so the subtraction yields all ones for w = 64.
      mask    = (64'd1 << w) - 64'd1;
      d       = data & mask;
      msb_vec = d >> (w - 1);
      // Top k bits of the word, replicated from the current MSB for SRA.
      fill    = msb_vec[0] ? (mask & ~(mask >> k)) : '0;
      case (op)
         OP_ROR:  return ((d >> k) | (d << (w - k))) & mask;
         OP_ROL:  return ((d << k) | (d >> (w - k))) & mask;
         OP_SRL:  return d >> k;
         default: return (d >> k) | fill;
      endcase
   endfunction

endpackage

// File: rtl/barrel_stage.sv
// One pipeline stage: conditional shift by 2^I plus its load/hold register.
module barrel_stage
   import barrel_pkg::*;
#(
   parameter int Width = 8,
   parameter int N     = 3,
   parameter int TagW  = 4,
   parameter int I     = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             up_valid,
   input  logic [Width-1:0] up_data,
   input  logic [N-1:0]     up_amt,
   input  logic [1:0]       up_op,
   input  logic [TagW-1:0]  up_tag,
   input  logic             load,
   output logic             valid,
   output logic [Width-1:0] data,
   output logic [N-1:0]     amt,
   output logic [1:0]       op,
   output logic [TagW-1:0]  tag
);

   localparam int unsigned K = 1 << I;

   logic             valid_reg;
   logic [Width-1:0] data_reg;
   logic [N-1:0]     amt_reg;
   logic [1:0]       op_reg;
   logic [TagW-1:0]  tag_reg;
   logic [Width-1:0] data_next;

   // Apply this stage's power-of-two step only when its amount bit is set.
   always_comb begin
      data_next = up_data;
      if (up_amt[I]) begin
         data_next = Width'(shift_step(MaxWidth'(up_data), Width, K, op_e'(up_op)));
      end
   end

   // Load everything from upstream when downstream can make room, else hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
         amt_reg   <= '0;
         op_reg    <= '0;
         tag_reg   <= '0;
      end else if (load) begin
         valid_reg <= up_valid;
         data_reg  <= data_next;
         amt_reg   <= up_amt;
         op_reg    <= up_op;
         tag_reg   <= up_tag;
      end
   end

   assign valid = valid_reg;
   assign data  = data_reg;
   assign amt   = amt_reg;
   assign op    = op_reg;
   assign tag   = tag_reg;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// N-stage barrel shifter/rotator with valid/ready on both sides and a carried tag.
module pipelined_barrel_shifter
   import barrel_pkg::*;
#(
   parameter  int N     = 3,
   parameter  int TagW  = 4,
   localparam int Width = 1 << N
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [Width-1:0] in_a,
   input  logic [N-1:0]     in_amt,
   input  logic [1:0]       in_op,
   input  logic [TagW-1:0]  in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [Width-1:0] out_y,
   output logic [TagW-1:0]  out_tag
);

   logic [N-1:0]     valid_chain;
   logic [Width-1:0] data_chain [N];
   logic [N-1:0]     amt_chain  [N];
   logic [1:0]       op_chain   [N];
   logic [TagW-1:0]  tag_chain  [N];
   logic [N:0]       rdy;

   // Ready ripples back from the consumer; an empty stage always accepts,
   // which lets bubbles collapse while the output is stalled.
   always_comb begin
      rdy    = '0;
      rdy[N] = out_ready;
      for (int i = N - 1; i >= 0; i--) begin
         rdy[i] = !valid_chain[i] || rdy[i+1];
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_stage
      logic             up_valid;
      logic [Width-1:0] up_data;
      logic [N-1:0]     up_amt;
      logic [1:0]       up_op;
      logic [TagW-1:0]  up_tag;

      if (gi == 0) begin : g_src_port
         assign up_valid = in_valid;
         assign up_data  = in_a;
         assign up_amt   = in_amt;
         assign up_op    = in_op;
         assign up_tag   = in_tag;
      end else begin : g_src_prev
         assign up_valid = valid_chain[gi-1];
         assign up_data  = data_chain[gi-1];
         assign up_amt   = amt_chain[gi-1];
         assign up_op    = op_chain[gi-1];
         assign up_tag   = tag_chain[gi-1];
      end

      barrel_stage #(
         .Width (Width),
         .N     (N),
         .TagW  (TagW),
         .I     (gi)
      ) u_stage (
         .clk      (clk),
         .reset    (reset),
         .up_valid (up_valid),
         .up_data  (up_data),
         .up_amt   (up_amt),
         .up_op    (up_op),
         .up_tag   (up_tag),
         .load     (rdy[gi]),
         .valid    (valid_chain[gi]),
         .data     (data_chain[gi]),
         .amt      (amt_chain[gi]),
         .op       (op_chain[gi]),
         .tag      (tag_chain[gi])
      );
   end

   // The last stage's amount and op have no further consumer.
   logic unused_tail;
   assign unused_tail = ^{amt_chain[N-1], op_chain[N-1]};

   assign in_ready  = rdy[0];
   assign out_valid = valid_chain[N-1];
   assign out_y     = data_chain[N-1];
   assign out_tag   = tag_chain[N-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench: directed ops, corner amounts, backpressure, random stalls,
// mid-stream reset, plus a random sweep on N = 1, 4 and 6 instances.
module tb_pipelined_barrel_shifter;

   localparam int MN = 3;
   localparam int MW = 1 << MN;
   localparam int RAND_WORDS  = 10000;
   localparam int SWEEP_WORDS = 2000;

   typedef struct {
      logic [63:0] y;
      logic [3:0]  tag;
      int          cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          sreset;
   logic          in_valid;
   logic          in_ready;
   logic [MW-1:0] in_a;
   logic [MN-1:0] in_amt;
   logic [1:0]    in_op;
   logic [3:0]    in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [MW-1:0] out_y;
   logic [3:0]    out_tag;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   lat_check = 1'b0;
   bit   rand_or = 1'b0;
   bit   [2:0] sweep_done = '0;
   exp_t sb[$];

   always #5 clk = ~clk;

   pipelined_barrel_shifter #(.N(MN), .TagW(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_amt    (in_amt),
      .in_op     (in_op),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_tag   (out_tag)
   );

   // Reference: whole-amount shift on a doubled / sign-extended wide word.
   function automatic logic [63:0] model(input logic [63:0] a, input int w,
                                         input int amt, input logic [1:0] op);
      logic [127:0] wide;
      logic [127:0] mask;
      logic [127:0] res;
      mask = (128'd1 << w) - 128'd1;
      wide = {64'd0, a} & mask;
      case (op)
         2'b00:   res = (wide | (wide << w)) >> amt;
         2'b01:   res = ((wide | (wide << w)) << amt) >> w;
         2'b10:   res = wide >> amt;
         default: begin
            if (((wide >> (w - 1)) & 128'd1) != 128'd0) wide = wide | ~mask;
            res = wide >> amt;
         end
      endcase
      return 64'(res & mask);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Offer one word (called and returning at posedge+1); push expectation on accept.
   task automatic send(input logic [MW-1:0] a, input int amt, input logic [1:0] op,
                       input logic [3:0] tag, input logic [MW-1:0] y, input int bound,
                       output bit ok);
      exp_t e;
      in_a = a; in_amt = MN'(amt); in_op = op; in_tag = tag; in_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < bound; t++) begin
         @(negedge clk);
         if (in_ready) begin
            e.y = 64'(y); e.tag = tag; e.cyc = cyc;
            sb.push_back(e);
            ok = 1'b1;
         end
         @(posedge clk); #1;
         if (ok) break;
      end
      in_valid = 1'b0;
   endtask

   task automatic put(input logic [MW-1:0] a, input int amt, input logic [1:0] op,
                      input logic [3:0] tag, input logic [MW-1:0] y);
      bit ok;
      send(a, amt, op, tag, y, 2000, ok);
      if (!ok) begin
         errors++;
         $display("FAIL accept_timeout actual=0 required=1 tag=%0d", tag);
      end
   endtask

   task automatic wait_drain(input int bound);
      int t;
      t = 0;
      while (sb.size() != 0 && t < bound) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_left", 64'(sb.size()), 64'd0);
   endtask

   // Randomised out_ready during the random phase, driven clear of the edge.
   initial forever begin
      @(posedge clk); #2;
      if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: pops and compares on every output handshake, checks stall stability.
   initial begin
      exp_t        e;
      bit          stall_prev;
      logic [MW-1:0] prev_y;
      logic [3:0]  prev_tag;
      stall_prev = 1'b0; prev_y = '0; prev_tag = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               chk("stall_valid", 64'(out_valid), 64'd1);
               chk("stall_y", 64'(out_y), 64'(prev_y));
               chk("stall_tag", 64'(out_tag), 64'(prev_tag));
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_out actual=%0h tag=%0d required=none", out_y, out_tag);
               end else begin
                  e = sb.pop_front();
                  $display("out y=%02h tag=%0d cyc=%0d", out_y, out_tag, cyc);
                  chk("out_y", 64'(out_y), e.y);
                  chk("out_tag", 64'(out_tag), 64'(e.tag));
                  if (lat_check) chk("latency", 64'(cyc - e.cyc), 64'(MN));
               end
            end
            stall_prev = out_valid && !out_ready;
            prev_y = out_y;
            prev_tag = out_tag;
         end
      end
   end

   // Width sweep: independent random runs on other N values.
   for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
      localparam int SN = (gi == 0) ? 1 : ((gi == 1) ? 4 : 6);
      localparam int SW = 1 << SN;
      logic          s_valid, s_ready, s_ovalid, s_ordy;
      logic [SW-1:0] s_a, s_y;
      logic [SN-1:0] s_amt;
      logic [1:0]    s_op;
      logic [3:0]    s_tag, s_otag;
      exp_t          s_sb[$];

      pipelined_barrel_shifter #(.N(SN), .TagW(4)) dut_s (
         .clk       (clk),
         .reset     (sreset),
         .in_valid  (s_valid),
         .in_ready  (s_ready),
         .in_a      (s_a),
         .in_amt    (s_amt),
         .in_op     (s_op),
         .in_tag    (s_tag),
         .out_valid (s_ovalid),
         .out_ready (s_ordy),
         .out_y     (s_y),
         .out_tag   (s_otag)
      );

      initial begin
         logic [63:0] r;
         exp_t        e;
         bit          acc;
         int          t;
         s_valid = 1'b0; s_ordy = 1'b1; s_a = '0; s_amt = '0; s_op = '0; s_tag = '0;
         @(negedge sreset);
         @(posedge clk); #1;
         for (int n = 0; n < SWEEP_WORDS; n++) begin
            r = {$urandom(), $urandom()};
            s_a = r[SW-1:0];
            s_amt = SN'($urandom_range(0, SW - 1));
            s_op = 2'($urandom_range(0, 3));
            s_tag = 4'($urandom_range(0, 15));
            s_valid = ($urandom_range(0, 3) != 0);
            acc = 1'b0;
            for (int k = 0; k < 2000 && !acc; k++) begin
               @(negedge clk);
               if (s_valid && s_ready) begin
                  e.y = model(64'(s_a), SW, int'(s_amt), s_op);
                  e.tag = s_tag; e.cyc = 0;
                  s_sb.push_back(e);
                  acc = 1'b1;
               end
               @(posedge clk); #1;
               s_ordy = ($urandom_range(0, 3) != 0);
               s_valid = 1'b1;
            end
            s_valid = 1'b0;
         end
         s_ordy = 1'b1;
         t = 0;
         while (s_sb.size() != 0 && t < 500) begin
            @(posedge clk); #1;
            t++;
         end
         chk($sformatf("sweep%0d_drain_left", SN), 64'(s_sb.size()), 64'd0);
         sweep_done[gi] = 1'b1;
      end

      initial forever begin
         exp_t e;
         @(negedge clk);
         if (!sreset && s_ovalid && s_ordy) begin
            if (s_sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL sweep%0d_unexpected actual=%0h required=none", SN, s_y);
            end else begin
               e = s_sb.pop_front();
               chk($sformatf("sweep%0d_y", SN), 64'(s_y), e.y);
               chk($sformatf("sweep%0d_tag", SN), 64'(s_otag), 64'(e.tag));
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // Main stimulus sequence.
   initial begin
      bit          ok;
      logic [MW-1:0] a;
      int          amt;
      logic [1:0]  op;
      logic [3:0]  tag;
      int          t;
      reset = 1'b1; sreset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_a = '0; in_amt = '0; in_op = '0; in_tag = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0; sreset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_y", 64'(out_y), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      // Directed ops, back-to-back, latency checked.
      lat_check = 1'b1;
      put(8'h96, 3, 2'b00, 4'd1, 8'hD2);
      put(8'h96, 3, 2'b01, 4'd2, 8'hB4);
      put(8'h96, 3, 2'b10, 4'd3, 8'h12);
      put(8'h96, 3, 2'b11, 4'd4, 8'hF2);
      // Corner amounts.
      for (int o = 0; o < 4; o++) put(8'hA5, 0, 2'(o), 4'(8 + o), 8'hA5);
      put(8'h80, 7, 2'b11, 4'd12, 8'hFF);
      put(8'h80, 7, 2'b10, 4'd13, 8'h01);
      put(8'h01, 7, 2'b01, 4'd14, 8'h80);
      wait_drain(50);
      lat_check = 1'b0;

      // Backpressure: three words fill the pipe, the fourth is refused.
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         a = 8'($urandom); amt = $urandom_range(0, 7); op = 2'($urandom_range(0, 3));
         put(a, amt, op, 4'(k + 1), 8'(model(64'(a), MW, amt, op)));
      end
      a = 8'h3C; amt = 2; op = 2'b11;
      send(a, amt, op, 4'd4, 8'(model(64'(a), MW, amt, op)), 6, ok);
      chk("bp_fourth_refused", 64'(ok), 64'd0);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_occupancy", 64'(sb.size()), 64'd3);
      out_ready = 1'b1;
      put(a, amt, op, 4'd4, 8'(model(64'(a), MW, amt, op)));
      a = 8'hC3; amt = 5; op = 2'b00;
      put(a, amt, op, 4'd5, 8'(model(64'(a), MW, amt, op)));
      wait_drain(50);

      // Random stalls on both sides.
      rand_or = 1'b1;
      for (int n = 0; n < RAND_WORDS; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         a = 8'($urandom); amt = $urandom_range(0, 7);
         op = 2'($urandom_range(0, 3)); tag = 4'($urandom_range(0, 15));
         put(a, amt, op, tag, 8'(model(64'(a), MW, amt, op)));
      end
      rand_or = 1'b0;
      out_ready = 1'b1;
      wait_drain(200);

      // Reset with three words in flight.
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) put(8'(8'h11 * (k + 1)), k, 2'b00, 4'(k + 7), 8'(model(64'(8'h11 * (k + 1)), MW, k, 2'b00)));
      #2 reset = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_out_y", 64'(out_y), 64'd0);
      chk("midrst_out_tag", 64'(out_tag), 64'd0);
      sb.delete();
      @(posedge clk); #3 reset = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("postrst_no_valid", 64'(out_valid), 64'd0);
      end
      @(posedge clk); #1;
      lat_check = 1'b1;
      put(8'h96, 1, 2'b11, 4'd15, 8'hCB);
      wait_drain(20);
      lat_check = 1'b0;

      t = 0;
      while (sweep_done != 3'b111 && t < 50000) begin
         @(posedge clk);
         t++;
      end
      chk("sweep_complete", 64'(sweep_done), 64'd7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_barrel_shifter.md
# pipelined_barrel_shifter

Parametrised, fully pipelined barrel shifter for 2^N-bit words with four operations: rotate right, rotate left, logical right shift and arithmetic right shift. It extends the combinational rotator family with one register stage per shift bit, valid/ready handshakes on both sides, and a user tag carried alongside each word. It sits between a streaming producer, such as an ALU operand path, and a consumer that may apply backpressure.

## Interface
- `N`, default 3: log2 of the data width; legal range 1..6.
- `Width`, localparam, `1 << N`: data width.
- `TagW`, default 4: width of the opaque tag carried with each word; must be ≥1.
- `clk` input 1: the only clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all stage-valid bits and output registers.
- `in_valid` input 1: an input word is offered.
- `in_ready` output 1: the block accepts the word this cycle.
- `in_a` input Width: operand.
- `in_amt` input N: shift/rotate amount, 0..Width-1.
- `in_op` input 2: operation, `op_e`.
- `in_tag` input TagW: carried unchanged to the output.
- `out_valid` output 1: the result is valid.
- `out_ready` input 1: the consumer accepts the result.
- `out_y` output Width: the result.
- `out_tag` output TagW: the tag of this result.

## Operation
- `op_e` encoding: `OP_ROR`=2'b00, `OP_ROL`=2'b01, `OP_SRL`=2'b10, `OP_SRA`=2'b11.
- N stages, numbered 0..N-1. Stage i applies a shift by 2^i when `amt[i]` is 1, otherwise it passes the word through. Its result goes into stage i's register.
- Each stage register holds `valid`, `data`, `amt`, `op` and `tag`. `amt` and `op` travel with the word.
- Per-stage shift by k=2^i:
  - ROR: `{d[k-1:0], d[W-1:k]}`.
  - ROL: `{d[W-k-1:0], d[W-1:W-k]}`.
  - SRL: `{k'0, d[W-1:k]}`.
  - SRA: `{{k{d[W-1]}}, d[W-1:k]}`. The sign bit is the current stage input's MSB. This is equivalent to the original operand's MSB, because SRA never changes the MSB.
- Bubble-collapsing ready chain:
  - `rdy[N] = out_ready`.
  - `rdy[i] = !valid[i] || rdy[i+1]`.
  - `in_ready = rdy[0]`.
- Stage i loads from stage i-1 (stage 0 loads from the input port) when `rdy[i]` is 1. Its new valid is the upstream valid.
- When `rdy[i]` is 0, stage i holds all fields.
- `out_valid = valid[N-1]`; `out_y` and `out_tag` come from stage N-1's register.
- Output fields stay stable while `out_valid && !out_ready`.
- `in_amt` = 0 passes the operand through unchanged for every op.
- There is no state machine beyond the per-stage valid bits. The pipeline holds at most N words.

## Timing
- Reset values: every `valid[i]`=0, data/tag registers=0, `out_valid`=0, `out_y`=0, `out_tag`=0.
- `in_ready` is 1 from the first cycle after reset is released.
- Latency: a word accepted in cycle t appears with `out_valid`=1 in cycle t+N when `out_ready` is held high.
- Throughput: one word per cycle while `out_ready`=1.
- Full condition: all N valids are 1 and `out_ready`=0. `in_ready` is then 0 in that same cycle, via a combinational path from `out_ready`.
- Simultaneous accept at the input and drain at the output, with the pipeline full and `out_ready`=1: both occur, and occupancy is unchanged.
- Reset asserted mid-stream: all in-flight words are discarded immediately. No partial word is emitted after release.
- `in_a`, `in_amt`, `in_op` and `in_tag` are don't-care when `in_valid`=0. Stage valids never change because of them.

## Structure
- Package `barrel_pkg`: the `op_e` enum and a function `shift_step(data, k, op)` that returns one stage's shift.
- Sub-module `barrel_stage`, parameterised by `Width`, `N`, `TagW` and stage index `I`:
  - one combinational shift step plus the stage register with its load/hold logic;
  - the top level generates N instances and wires the `rdy` chain.

## Test plan
- Directed ops, N=3, `in_a`=8'h96, `in_amt`=3, back-to-back:
  - ROR → 8'hD2;
  - ROL → 8'hB4;
  - SRL → 8'h12;
  - SRA → 8'hF2.
  - Each appears exactly 3 cycles after acceptance, with its own tag (1, 2, 3, 4).
- Corner amounts:
  - `in_amt`=0 on every op with `in_a`=8'hA5 → 8'hA5;
  - `in_amt`=7, SRA on 8'h80 → 8'hFF;
  - `in_amt`=7, SRL on 8'h80 → 8'h01;
  - `in_amt`=7, ROL on 8'h01 → 8'h80.
- Backpressure:
  - hold `out_ready`=0 while offering 5 words → exactly 3 accepted, then `in_ready`=0;
  - release → the 3 words drain in order with correct tags, and the remaining 2 follow;
  - no word is lost or duplicated.
- Random stall: random `in_valid`/`out_ready` toggling over 10k words, checked against a scoreboard reference model computed per op for all `in_amt`.
- Reset mid-stream: assert `reset` asynchronously with 3 words in flight.
  - All outputs read 0 in the same cycle.
  - After release there is no `out_valid` until a new word has been accepted N cycles earlier.
- Width sweep: repeat the random test for N=1, 4 and 6.
